// File: rtl/exu_cmt_sched.sv
// Commit scheduler: an order FIFO records ALU/LSU dispatch order, and commit
// requests are granted strictly in that order into one registered output slot.
module exu_cmt_sched #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned INSTR_SIZE = 32,
  parameter int unsigned XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic                  disp_src,
  input  logic                  flush,

  input  logic                  alu_cmt_valid,
  output logic                  alu_cmt_ready,
  input  logic [PC_SIZE-1:0]    alu_cmt_pc,
  input  logic [INSTR_SIZE-1:0] alu_cmt_instr,
  input  logic [XLEN-1:0]       alu_cmt_imm,
  input  logic                  alu_cmt_bjp,
  input  logic                  alu_cmt_ebreak,
  input  logic                  alu_cmt_bjp_prdt,

  input  logic                  lsu_cmt_valid,
  output logic                  lsu_cmt_ready,
  input  logic [PC_SIZE-1:0]    lsu_cmt_pc,
  input  logic [INSTR_SIZE-1:0] lsu_cmt_instr,

  output logic                  cmt_o_valid,
  input  logic                  cmt_o_ready,
  output logic [PC_SIZE-1:0]    cmt_o_pc,
  output logic [INSTR_SIZE-1:0] cmt_o_instr,
  output logic [XLEN-1:0]       cmt_o_imm,
  output logic                  cmt_o_bjp,
  output logic                  cmt_o_ebreak,
  output logic                  cmt_o_bjp_prdt,
  output logic                  cmt_o_src,

  output logic                  oitf_empty,
  output logic                  oitf_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] fifo;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;

  logic head;
  logic out_free;
  logic push;
  logic pop;
  logic alu_grant;
  logic lsu_grant;

  assign oitf_empty = (cnt == '0);
  assign oitf_full  = (cnt == CW'(DEPTH));
  assign head       = fifo[rptr];
  assign out_free   = !cmt_o_valid | cmt_o_ready;

  // disp_ready already excludes the full case, so a pop cannot make room
  // for a push in the same cycle.
  assign disp_ready = !oitf_full & !flush;
  assign push       = disp_valid & disp_ready;

  assign alu_cmt_ready = out_free & !oitf_empty & !head & !flush;
  assign lsu_cmt_ready = out_free & !oitf_empty &  head & !flush;
  assign alu_grant     = alu_cmt_valid & alu_cmt_ready;
  assign lsu_grant     = lsu_cmt_valid & lsu_cmt_ready;
  assign pop           = alu_grant | lsu_grant;

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo <= '0;
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= disp_src;
        wptr       <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmt_o_valid    <= 1'b0;
      cmt_o_pc       <= '0;
      cmt_o_instr    <= '0;
      cmt_o_imm      <= '0;
      cmt_o_bjp      <= 1'b0;
      cmt_o_ebreak   <= 1'b0;
      cmt_o_bjp_prdt <= 1'b0;
      cmt_o_src      <= 1'b0;
    end else if (alu_grant) begin
      cmt_o_valid    <= 1'b1;
      cmt_o_pc       <= alu_cmt_pc;
      cmt_o_instr    <= alu_cmt_instr;
      cmt_o_imm      <= alu_cmt_imm;
      cmt_o_bjp      <= alu_cmt_bjp;
      cmt_o_ebreak   <= alu_cmt_ebreak;
      cmt_o_bjp_prdt <= alu_cmt_bjp_prdt;
      cmt_o_src      <= 1'b0;
    end else if (lsu_grant) begin
      cmt_o_valid    <= 1'b1;
      cmt_o_pc       <= lsu_cmt_pc;
      cmt_o_instr    <= lsu_cmt_instr;
      cmt_o_imm      <= '0;
      cmt_o_bjp      <= 1'b0;
      cmt_o_ebreak   <= 1'b0;
      cmt_o_bjp_prdt <= 1'b0;
      cmt_o_src      <= 1'b1;
    end else if (cmt_o_ready) begin
      cmt_o_valid <= 1'b0;
    end
  end

endmodule

// File: doc/exu_cmt_sched.md
EXU_CMT_SCHED -- requirements
Module: exu_cmt_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the order-FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; it SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port disp_valid, input, 1, dispatch of one instruction to the EXU.
REQ-005 The block SHALL have port disp_ready, output, 1, dispatch accepted this cycle.
REQ-006 The block SHALL have port disp_src, input, 1, instruction source: 0=ALU, 1=LSU.
REQ-007 The block SHALL have port flush, input, 1, one-cycle pipeline flush pulse.
REQ-008 The block SHALL have ports alu_cmt_valid (input, 1) and alu_cmt_ready (output, 1), the ALU commit request handshake.
REQ-009 The block SHALL have ports alu_cmt_pc (input, PC_SIZE), alu_cmt_instr (input, INSTR_SIZE) and alu_cmt_imm (input, XLEN), the ALU commit payload.
REQ-010 The block SHALL have ports alu_cmt_bjp, alu_cmt_ebreak and alu_cmt_bjp_prdt (each input, 1), the ALU commit flags.
REQ-011 The block SHALL have ports lsu_cmt_valid (input, 1), lsu_cmt_ready (output, 1), lsu_cmt_pc (input, PC_SIZE) and lsu_cmt_instr (input, INSTR_SIZE), the LSU commit request and payload.
REQ-012 The block SHALL have ports cmt_o_valid (output, 1) and cmt_o_ready (input, 1), the handshake to the commit unit.
REQ-013 The block SHALL have ports cmt_o_pc (output, PC_SIZE), cmt_o_instr (output, INSTR_SIZE) and cmt_o_imm (output, XLEN), the registered commit payload.
REQ-014 The block SHALL have ports cmt_o_bjp, cmt_o_ebreak, cmt_o_bjp_prdt and cmt_o_src (each output, 1), the registered flags plus the source id.
REQ-015 The block SHALL have ports oitf_empty and oitf_full (each output, 1), the order-FIFO status.

Function
REQ-016 The block SHALL hold a DEPTH-entry circular order FIFO of 1-bit source ids, with read/write pointers that wrap modulo DEPTH and a count of width log2(DEPTH)+1.
REQ-017 disp_ready SHALL equal !oitf_full & !flush; a dispatch SHALL push disp_src exactly when disp_valid & disp_ready.
REQ-018 A full FIFO SHALL refuse a push even in a cycle that pops; push-and-pop in the same cycle SHALL leave the count unchanged.
REQ-019 The output register SHALL be free when !cmt_o_valid | cmt_o_ready.
REQ-020 Grant: alu_cmt_ready SHALL equal free & !oitf_empty & head==0 & !flush.
REQ-021 Grant: lsu_cmt_ready SHALL equal free & !oitf_empty & head==1 & !flush; a non-head requester SHALL see ready=0 whatever its valid.
REQ-022 On a granted handshake (valid&ready), the payload SHALL load into the cmt_o_* registers, cmt_o_valid SHALL be set the next cycle (latency 1), and the FIFO SHALL pop.
REQ-023 An LSU load SHALL set cmt_o_imm=0, cmt_o_bjp=0, cmt_o_ebreak=0, cmt_o_bjp_prdt=0 and cmt_o_src=1.
REQ-024 cmt_o_valid SHALL clear when cmt_o_ready is high and no new grant occurs; while cmt_o_valid & !cmt_o_ready all cmt_o_* SHALL hold stable.
REQ-025 With an empty FIFO there SHALL be no grant; an entry pushed in cycle N SHALL be grantable no earlier than cycle N+1.
REQ-026 flush SHALL reset the pointers and count to 0, drop any push and grant that cycle, and leave the output register and its handshake untouched.
REQ-027 oitf_empty SHALL be (count==0) and oitf_full SHALL be (count==DEPTH), both derived from registered state.

Reset
REQ-028 While rst=0: pointers=0, count=0, cmt_o_valid=0, all cmt_o_* payload and flags=0, oitf_empty=1, oitf_full=0, disp_ready=1 (absent flush).
REQ-029 Reset asserted mid-transfer SHALL discard the held commit and all FIFO contents immediately, without waiting for a clock edge.

Verification
REQ-030 Dispatch ALU, LSU, ALU; LSU valid first, ALU valid continuously -> commits emerge in order src 0,1,0, each 1 cycle after its grant.
REQ-031 With DEPTH=4, push 4 and hold cmt_o_ready=0 -> oitf_full=1 and disp_ready=0; raise cmt_o_ready -> one pop, disp_ready=1 the next cycle.
REQ-032 Hold cmt_o_ready=0 for 3 cycles with cmt_o_valid=1 -> pc/instr/flags stable; a release gives exactly one transfer.
REQ-033 Pulse flush with 3 entries queued while cmt_o_valid=1 -> count=0 and oitf_empty=1 next cycle, the held commit still completes, and a same-cycle dispatch is ignored.
REQ-034 Perform 10 push/pop cycles at DEPTH=4 -> pointers wrap correctly and order is preserved across the wrap.
REQ-035 Assert rst low asynchronously between clock edges with cmt_o_valid=1 -> cmt_o_valid=0 and oitf_empty=1 before the next edge.
